psum_drain: RTL and testbench

PSUM_DRAIN -- requirements
Module: psum_drain

---
 rtl/psum_drain.sv | 159 +++++++++++++++
 tb/tb_psum_drain.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain.sv
// psum_drain: reads a contiguous range of psum SRAM words and streams them
// out through a 2-entry FIFO with a valid/ready handshake.
// Optional build macro PSUM_DRAIN_RELU_EN clamps negative output lanes to 0.
module psum_drain #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int addr_bw = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [addr_bw-1:0]     base_addr,
    input  logic [addr_bw:0]       count,
    output logic                   busy,
    output logic                   done,
    output logic                   sram_cen,
    output logic                   sram_wen,
    output logic [addr_bw-1:0]     sram_a,
    input  logic [col*psum_bw-1:0] sram_q,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [col*psum_bw-1:0] out_data
);

    localparam int word_bw = col * psum_bw;
    localparam logic [addr_bw:0] last_read = {{addr_bw{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t             state;
    logic [addr_bw-1:0] addr;
    logic [addr_bw:0]   reads_left;
    logic               in_flight;

    logic [word_bw-1:0] fifo_mem [2];
    logic               rd_ptr;
    logic               wr_ptr;
    logic [1:0]         occ;

    logic               issue;
    logic               pop;
    logic               push;
    logic [2:0]         credit_used;
    logic [word_bw-1:0] head;

    assign sram_wen  = 1'b1;
    assign sram_a    = addr;
    assign sram_cen  = ~issue;
    assign out_valid = (occ != 2'd0);

    // Read-issue and FIFO control; a head pop in the same cycle frees its slot
    // for the new read, which is what allows one word per cycle to be sustained.
    always_comb begin
        pop         = out_valid && out_ready;
        push        = in_flight;
        credit_used = {1'b0, occ} + {2'b00, in_flight} - {2'b00, pop};
        issue       = (state == RUN) && !reset && (credit_used < 3'd2);
    end

    // Control FSM: address/length tracking, busy/done and read-in-flight flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr       <= '0;
            reads_left <= '0;
            in_flight  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done      <= 1'b0;
            in_flight <= issue;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            done <= 1'b1;
                        end else begin
                            state      <= RUN;
                            busy       <= 1'b1;
                            addr       <= base_addr;
                            reads_left <= count;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr       <= addr + 1'b1;
                        reads_left <= reads_left - 1'b1;
                        if (reads_left == last_read) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // Leave on the final handshake itself so done/busy change
                    // in the very next cycle.
                    if (pop && (occ == 2'd1) && !in_flight) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        addr  <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // FIFO storage; data landing in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            fifo_mem[wr_ptr] <= sram_q;
        end
    end

    // Output word from the FIFO head, zero when empty.
    always_comb begin
        head     = fifo_mem[rd_ptr];
        out_data = '0;
        if (out_valid) begin
            out_data = head;
`ifdef PSUM_DRAIN_RELU_EN
            for (int unsigned k = 0; k < col; k++) begin
                if (head[k*psum_bw + psum_bw - 1]) begin
                    out_data[k*psum_bw +: psum_bw] = '0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain: SRAM model, queue-based reference
// model checked every cycle, directed scenarios and randomized drains.
module tb_psum_drain;

    localparam int PB  = 16;
    localparam int COL = 8;
    localparam int AB  = 11;
    localparam int WB  = PB * COL;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AB-1:0] base_addr;
    logic [AB:0]   count;
    logic          busy;
    logic          done;
    logic          sram_cen;
    logic          sram_wen;
    logic [AB-1:0] sram_a;
    logic [WB-1:0] sram_q;
    logic          out_valid;
    logic          out_ready;
    logic [WB-1:0] out_data;

    psum_drain #(.psum_bw(PB), .col(COL), .addr_bw(AB)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_a    (sram_a),
        .sram_q    (sram_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    logic [WB-1:0] salt = '0;
    int            ready_mode = 0;
    logic          ready_val  = 1'b0;

    // SRAM contents: every lane holds its address, xored with a per-run salt.
    function automatic logic [WB-1:0] word_of(input logic [AB-1:0] a, input logic [WB-1:0] s);
        logic [WB-1:0] w;
        for (int k = 0; k < COL; k++) w[k*PB +: PB] = {5'b00000, a};
        return w ^ s;
    endfunction

    function automatic logic [WB-1:0] expect_out(input logic [WB-1:0] w);
        logic [WB-1:0] r;
        r = w;
`ifdef PSUM_DRAIN_RELU_EN
        for (int k = 0; k < COL; k++) if ($signed(w[k*PB +: PB]) < 0) r[k*PB +: PB] = '0;
`endif
        return r;
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SRAM: one-cycle read latency, garbage on non-read cycles.
    always @(posedge clk) begin
        if (sram_cen === 1'b0) sram_q <= word_of(sram_a, salt);
        else sram_q <= {$urandom, $urandom, $urandom, $urandom};
    end

    // Consumer ready: fixed level or random.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            out_ready = (ready_mode != 0) ? ($urandom_range(0, 3) != 0) : ready_val;
        end
    end

    // Reference model: pending read addresses and words to deliver.
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    logic [AB-1:0] addr_q[$];
    logic [WB-1:0] data_q[$];
    int            issued = 0, delivered = 0, remaining = 0;

    always @(negedge clk) begin
        logic hs, cur_busy;
        int n;
        if (reset) begin
            m_busy = 1'b0; m_done = 1'b0;
            addr_q.delete(); data_q.delete();
            issued = 0; delivered = 0; remaining = 0;
        end else begin
            hs = out_valid && out_ready;
            check_int("wen_high", int'(sram_wen), 1);
            check_int("busy", int'(busy), int'(m_busy));
            check_int("done", int'(done), int'(m_done));
            if (!m_busy) begin
                check_int("idle_cen", int'(sram_cen), 1);
                check_int("idle_addr", int'(sram_a), 0);
                check_int("idle_valid", int'(out_valid), 0);
            end
            if (sram_cen === 1'b0) begin
                issued++;
                checks++;
                if (addr_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_read: read at %0d with no read pending", sram_a);
                end else check_int("read_addr", int'(sram_a), int'(addr_q.pop_front()));
            end
            if (out_valid) begin
                checks++;
                if (data_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_word: out_valid with nothing pending, data %h", out_data);
                end else if (hs) begin
                    check_word("out_data", out_data, data_q.pop_front());
                end
            end
            if (hs) delivered++;
            if (m_busy) check_int("read_ahead_le2", int'(issued - delivered <= 2), 1);

            cur_busy = m_busy;
            m_done = 1'b0;
            if (hs && remaining > 0) begin
                remaining--;
                if (remaining == 0) begin m_busy = 1'b0; m_done = 1'b1; end
            end
            if (!cur_busy && start) begin
                n = int'(count);
                if (n == 0) m_done = 1'b1;
                else begin
                    m_busy = 1'b1; remaining = n; issued = 0; delivered = 0;
                    for (int i = 0; i < n; i++) begin
                        addr_q.push_back(AB'(int'(base_addr) + i));
                        data_q.push_back(expect_out(word_of(AB'(int'(base_addr) + i), salt)));
                    end
                end
            end
        end
    end

    task automatic do_start(input logic [AB-1:0] b, input logic [AB:0] n, output int sc);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; count = n; sc = cyc;
        @(posedge clk); #1;
        start = 1'b0; base_addr = AB'($urandom); count = (AB+1)'($urandom);
    endtask

    initial begin
        int sc, first_cen, first_v, nv, ndone, done_c, nreads, hcnt, ncen, nbusy;
        int lanes[8];
        int vcyc[8];
        int addrs[4];
        logic [WB-1:0] first_word, got;
        logic ok;

        reset = 1'b1; start = 1'b0; base_addr = '0; count = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_done", int'(done), 0);
        check_int("rst_valid", int'(out_valid), 0);
        check_word("rst_data", out_data, '0);
        check_int("rst_cen", int'(sram_cen), 1);
        check_int("rst_addr", int'(sram_a), 0);

        // base 5, count 4, ready high
        salt = '0; ready_val = 1'b1;
        do_start(11'd5, 12'd4, sc);
        first_cen = -1; first_v = -1; nv = 0; ndone = 0; done_c = -1; first_word = '0;
        repeat (15) begin
            @(negedge clk);
            if (!sram_cen && first_cen < 0) first_cen = cyc;
            if (out_valid && nv < 8) begin
                if (first_v < 0) begin first_v = cyc; first_word = out_data; end
                lanes[nv] = int'(out_data[15:0]); vcyc[nv] = cyc; nv++;
            end
            if (done) begin ndone++; done_c = cyc; end
        end
        check_int("d1_first_cen", first_cen, sc + 1);
        check_int("d1_latency", first_v, first_cen + 2);
        check_int("d1_nwords", nv, 4);
        check_int("d1_w0", lanes[0], 5);
        check_int("d1_w1", lanes[1], 6);
        check_int("d1_w2", lanes[2], 7);
        check_int("d1_w3", lanes[3], 8);
        check_int("d1_back_to_back", vcyc[3], first_v + 3);
        check_word("d1_word0", first_word, {8{16'h0005}});
        check_int("d1_ndone", ndone, 1);
        check_int("d1_done_cyc", done_c, first_v + 4);

        // address wrap
        do_start(11'd2046, 12'd3, sc);
        nreads = 0;
        repeat (12) begin
            @(negedge clk);
            if (!sram_cen) begin
                if (nreads < 4) addrs[nreads] = int'(sram_a);
                nreads++;
            end
        end
        check_int("wrap_nreads", nreads, 3);
        check_int("wrap_a0", addrs[0], 2046);
        check_int("wrap_a1", addrs[1], 2047);
        check_int("wrap_a2", addrs[2], 0);

        // stalled consumer
        ready_val = 1'b0;
        do_start(11'd100, 12'd6, sc);
        nreads = 0;
        repeat (10) begin
            @(negedge clk);
            if (!sram_cen) nreads++;
        end
        check_int("stall_reads", nreads, 2);
        @(posedge clk); #1 ready_val = 1'b1;
        hcnt = 0; ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid && out_ready) hcnt++;
            if (done) ndone++;
        end
        check_int("stall_words", hcnt, 6);
        check_int("stall_ndone", ndone, 1);

        // zero-length drain
        do_start(11'd7, 12'd0, sc);
        ncen = 0; nbusy = 0; ndone = 0; done_c = -1;
        repeat (5) begin
            @(negedge clk);
            if (!sram_cen) ncen++;
            if (busy) nbusy++;
            if (done) begin ndone++; done_c = cyc; end
        end
        check_int("zero_ncen", ncen, 0);
        check_int("zero_nbusy", nbusy, 0);
        check_int("zero_ndone", ndone, 1);
        check_int("zero_done_cyc", done_c, sc + 1);

        // reset mid-drain
        do_start(11'd0, 12'd8, sc);
        hcnt = 0;
        for (int i = 0; i < 20 && hcnt < 2; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) hcnt++;
        end
        check_int("abort_pre_words", hcnt, 2);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_int("abort_busy", int'(busy), 0);
        check_int("abort_done", int'(done), 0);
        check_int("abort_valid", int'(out_valid), 0);
        check_word("abort_data", out_data, '0);
        check_int("abort_cen", int'(sram_cen), 1);
        check_int("abort_wen", int'(sram_wen), 1);
        check_int("abort_addr", int'(sram_a), 0);
        ndone = 0; ncen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
            if (!sram_cen) ncen++;
        end
        check_int("abort_no_done", ndone, 0);
        check_int("abort_no_read", ncen, 0);
        salt = 128'h1111_2222_3333_4444_5555_6666_7777_0123;
        do_start(11'd0, 12'd1, sc);
        hcnt = 0; ndone = 0; got = '0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid && out_ready) begin hcnt++; got = out_data; end
            if (done) ndone++;
        end
        check_int("restart_words", hcnt, 1);
        check_word("restart_data", got, 128'h1111_2222_3333_4444_5555_6666_7777_0123);
        check_int("restart_ndone", ndone, 1);

`ifdef PSUM_DRAIN_RELU_EN
        salt = {4{16'h0010, 16'hFFF0}};
        do_start(11'd0, 12'd1, sc);
        got = '0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid && out_ready) got = out_data;
        end
        check_word("relu_lanes", got, {4{16'h0010, 16'h0000}});
`endif

        // randomized drains with random back-pressure and ignored starts
        ready_mode = 1;
        for (int it = 0; it < 30; it++) begin
            salt = {$urandom, $urandom, $urandom, $urandom};
            do_start(AB'($urandom), (it == 7) ? 12'd2048 : (AB+1)'($urandom_range(0, 40)), sc);
            ok = 1'b0;
            for (int t = 0; t < 6000; t++) begin
                if (!m_busy && !m_done) begin ok = 1'b1; break; end
                start = m_busy && ($urandom_range(0, 4) == 0);
                base_addr = AB'($urandom);
                count = (AB+1)'($urandom);
                @(posedge clk); #1;
            end
            start = 1'b0;
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL drain_timeout: iteration %0d busy=%0b expected idle", it, busy);
            end
        end
        ready_mode = 0;
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
